// File: rtl/unified_buffer_arbiter.sv
// -----------------------------------------------------------------------------
// unified_buffer_arbiter
//
// Shares the single-port unified buffer between three requesters and issues at
// most one registered memory command per cycle. Read data coming back from the
// buffer is steered to the requester that issued the read.
//
//   rd   : array-feed read controller, read-only, highest base priority
//   wb   : accumulator writeback, write-only
//   host : host port, read or write
//
// Priority (highest first): wb aged, host aged, rd, wb, host.
// A wb/host request that has waited MAX_WAIT cycles is "aged" and is promoted
// above rd, so continuous rd streaming cannot starve the other two.
//
// Ports
//   clk_i, rst_i                      clock, asynchronous active-high reset
//   rd_req_i/rd_addr_i                array-feed request and address
//   rd_gnt_o                          array-feed grant (combinational)
//   rd_rdata_o/rd_rvalid_o            array-feed read return
//   wb_req_i/wb_addr_i/wb_wdata_i     writeback request, address, data
//   wb_gnt_o                          writeback grant (combinational)
//   host_req_i/host_we_i              host request, write(1)/read(0)
//   host_addr_i/host_wdata_i          host address and write data
//   host_gnt_o                        host grant (combinational)
//   host_rdata_o/host_rvalid_o        host read return
//   ub_en_o/ub_we_o                   memory enable / write enable (registered)
//   ub_addr_o/ub_wdata_o              memory address / write data (registered)
//   ub_rdata_i                        memory read data, 1 cycle after command
// -----------------------------------------------------------------------------
module unified_buffer_arbiter #(
  parameter int unsigned ADDR_W   = 12,
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,

  input  logic              rd_req_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic              rd_gnt_o,
  output logic [DATA_W-1:0] rd_rdata_o,
  output logic              rd_rvalid_o,

  input  logic              wb_req_i,
  input  logic [ADDR_W-1:0] wb_addr_i,
  input  logic [DATA_W-1:0] wb_wdata_i,
  output logic              wb_gnt_o,

  input  logic              host_req_i,
  input  logic              host_we_i,
  input  logic [ADDR_W-1:0] host_addr_i,
  input  logic [DATA_W-1:0] host_wdata_i,
  output logic              host_gnt_o,
  output logic [DATA_W-1:0] host_rdata_o,
  output logic              host_rvalid_o,

  output logic              ub_en_o,
  output logic              ub_we_o,
  output logic [ADDR_W-1:0] ub_addr_o,
  output logic [DATA_W-1:0] ub_wdata_o,
  input  logic [DATA_W-1:0] ub_rdata_i
);

  // Owner of a read command; follows the command down to the data return.
  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_RD   = 2'd1,
    TAG_HOST = 2'd2
  } tag_e;

  localparam logic [7:0] L_MAX_WAIT = 8'(MAX_WAIT);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [7:0]        r_wb_wait;
  logic [7:0]        r_host_wait;

  logic              r_ub_en;
  logic              r_ub_we;
  logic [ADDR_W-1:0] r_ub_addr;
  logic [DATA_W-1:0] r_ub_wdata;

  tag_e              r_tag_cmd;   // aligned with the command on ub_*_o
  tag_e              r_tag_ret;   // aligned with ub_rdata_i

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  logic w_wb_aged;
  logic w_host_aged;
  logic w_gnt_rd;
  logic w_gnt_wb;
  logic w_gnt_host;
  logic w_any_gnt;
  tag_e w_tag_next;

  // The counters are only non-zero while the matching req is held, but the req
  // term keeps a dropped request from being granted in the cycle it falls.
  assign w_wb_aged   = wb_req_i   && (r_wb_wait   == L_MAX_WAIT);
  assign w_host_aged = host_req_i && (r_host_wait == L_MAX_WAIT);

  always_comb begin
    w_gnt_rd   = 1'b0;
    w_gnt_wb   = 1'b0;
    w_gnt_host = 1'b0;
    if (!rst_i) begin
      if (w_wb_aged)        w_gnt_wb   = 1'b1;
      else if (w_host_aged) w_gnt_host = 1'b1;
      else if (rd_req_i)    w_gnt_rd   = 1'b1;
      else if (wb_req_i)    w_gnt_wb   = 1'b1;
      else if (host_req_i)  w_gnt_host = 1'b1;
    end
  end

  assign w_any_gnt = w_gnt_rd | w_gnt_wb | w_gnt_host;

  always_comb begin
    w_tag_next = TAG_NONE;
    if (w_gnt_rd)                    w_tag_next = TAG_RD;
    else if (w_gnt_host && !host_we_i) w_tag_next = TAG_HOST;
  end

  // ---------------------------------------------------------------------------
  // Wait counters: count cycles spent requesting without a grant, saturating at
  // MAX_WAIT so an aged requester stays aged until it is served.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wb_wait   <= '0;
      r_host_wait <= '0;
    end else begin
      if (!wb_req_i || w_gnt_wb)
        r_wb_wait <= '0;
      else if (r_wb_wait != L_MAX_WAIT)
        r_wb_wait <= r_wb_wait + 8'd1;

      if (!host_req_i || w_gnt_host)
        r_host_wait <= '0;
      else if (r_host_wait != L_MAX_WAIT)
        r_host_wait <= r_host_wait + 8'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Memory command register. Address and data hold their last value when no
  // grant is issued; an rd read has no write data, so wdata is left alone.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ub_en    <= 1'b0;
      r_ub_we    <= 1'b0;
      r_ub_addr  <= '0;
      r_ub_wdata <= '0;
    end else begin
      r_ub_en <= w_any_gnt;
      r_ub_we <= w_gnt_wb | (w_gnt_host & host_we_i);
      if (w_gnt_wb) begin
        r_ub_addr  <= wb_addr_i;
        r_ub_wdata <= wb_wdata_i;
      end else if (w_gnt_host) begin
        r_ub_addr  <= host_addr_i;
        r_ub_wdata <= host_wdata_i;
      end else if (w_gnt_rd) begin
        r_ub_addr  <= rd_addr_i;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read-tag pipeline. Clearing it on reset drops any read in flight.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_tag_cmd <= TAG_NONE;
      r_tag_ret <= TAG_NONE;
    end else begin
      r_tag_cmd <= w_tag_next;
      r_tag_ret <= r_tag_cmd;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign rd_gnt_o      = w_gnt_rd;
  assign wb_gnt_o      = w_gnt_wb;
  assign host_gnt_o    = w_gnt_host;

  assign ub_en_o       = r_ub_en;
  assign ub_we_o       = r_ub_we;
  assign ub_addr_o     = r_ub_addr;
  assign ub_wdata_o    = r_ub_wdata;

  assign rd_rdata_o    = ub_rdata_i;
  assign host_rdata_o  = ub_rdata_i;
  assign rd_rvalid_o   = (r_tag_ret == TAG_RD);
  assign host_rvalid_o = (r_tag_ret == TAG_HOST);

endmodule

// File: tb/tb_unified_buffer_arbiter.sv
// -----------------------------------------------------------------------------
// tb_unified_buffer_arbiter
//
// Directed scenarios followed by randomized traffic. A transaction-level model
// decides each cycle which requester should win (from how long each one has
// been waiting), keeps a shadow of the buffer contents in grant order, and
// schedules the expected read returns two cycles after each read grant.
// -----------------------------------------------------------------------------
module tb_unified_buffer_arbiter;

  localparam int unsigned ADDR_W   = 12;
  localparam int unsigned DATA_W   = 64;
  localparam int unsigned MAX_WAIT = 8;
  localparam int unsigned DEPTH    = 1 << ADDR_W;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              rd_req_i;
  logic [ADDR_W-1:0] rd_addr_i;
  logic              rd_gnt_o;
  logic [DATA_W-1:0] rd_rdata_o;
  logic              rd_rvalid_o;
  logic              wb_req_i;
  logic [ADDR_W-1:0] wb_addr_i;
  logic [DATA_W-1:0] wb_wdata_i;
  logic              wb_gnt_o;
  logic              host_req_i;
  logic              host_we_i;
  logic [ADDR_W-1:0] host_addr_i;
  logic [DATA_W-1:0] host_wdata_i;
  logic              host_gnt_o;
  logic [DATA_W-1:0] host_rdata_o;
  logic              host_rvalid_o;
  logic              ub_en_o;
  logic              ub_we_o;
  logic [ADDR_W-1:0] ub_addr_o;
  logic [DATA_W-1:0] ub_wdata_o;
  logic [DATA_W-1:0] ub_rdata_i = '0;

  always #5 clk_i = ~clk_i;

  unified_buffer_arbiter #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .rd_req_i     (rd_req_i),
    .rd_addr_i    (rd_addr_i),
    .rd_gnt_o     (rd_gnt_o),
    .rd_rdata_o   (rd_rdata_o),
    .rd_rvalid_o  (rd_rvalid_o),
    .wb_req_i     (wb_req_i),
    .wb_addr_i    (wb_addr_i),
    .wb_wdata_i   (wb_wdata_i),
    .wb_gnt_o     (wb_gnt_o),
    .host_req_i   (host_req_i),
    .host_we_i    (host_we_i),
    .host_addr_i  (host_addr_i),
    .host_wdata_i (host_wdata_i),
    .host_gnt_o   (host_gnt_o),
    .host_rdata_o (host_rdata_o),
    .host_rvalid_o(host_rvalid_o),
    .ub_en_o      (ub_en_o),
    .ub_we_o      (ub_we_o),
    .ub_addr_o    (ub_addr_o),
    .ub_wdata_o   (ub_wdata_o),
    .ub_rdata_i   (ub_rdata_i)
  );

  // Unified buffer: one access per cycle, read data one cycle after command.
  logic [DATA_W-1:0] mem     [DEPTH];
  logic [DATA_W-1:0] ref_mem [DEPTH];

  always @(posedge clk_i) begin
    if (ub_en_o) begin
      if (ub_we_o) mem[ub_addr_o] <= ub_wdata_o;
      else         ub_rdata_i     <= mem[ub_addr_o];
    end
  end

  // ---------------------------------------------------------------------------
  // Reference model state
  // ---------------------------------------------------------------------------
  typedef struct {
    int unsigned       due;
    bit                to_host;
    logic [DATA_W-1:0] data;
  } ret_t;

  ret_t              ret_q[$];
  int unsigned       cyc = 0;
  int unsigned       wb_waited = 0;
  int unsigned       host_waited = 0;
  bit                m_gnt_rd, m_gnt_wb, m_gnt_host;
  bit                e_en, e_we;
  logic [ADDR_W-1:0] e_addr;
  logic [DATA_W-1:0] e_wdata;
  bit                pend_wr;
  logic [ADDR_W-1:0] pend_addr;
  logic [DATA_W-1:0] pend_data;

  // DUT observations captured at the last sampling point
  logic              d_gnt_wb, d_gnt_host, d_host_rvalid, d_rd_rvalid;
  logic [DATA_W-1:0] d_host_rdata;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // One clock cycle: sample on the falling edge, compare with the model,
  // advance the model, then return 1 time unit after the next rising edge.
  task automatic step();
    bit   erd, ewb, ehost;
    ret_t r;
    @(negedge clk_i);
    d_gnt_wb      = wb_gnt_o;
    d_gnt_host    = host_gnt_o;
    d_host_rvalid = host_rvalid_o;
    d_rd_rvalid   = rd_rvalid_o;
    d_host_rdata  = host_rdata_o;
    if (rst_i) begin
      check("rst_gnt",    64'({rd_gnt_o, wb_gnt_o, host_gnt_o}), 64'd0);
      check("rst_ub_en",  64'(ub_en_o), 64'd0);
      check("rst_ub_we",  64'(ub_we_o), 64'd0);
      check("rst_ub_addr", 64'(ub_addr_o), 64'd0);
      check("rst_ub_wdata", ub_wdata_o, 64'd0);
      check("rst_rvalid", 64'({rd_rvalid_o, host_rvalid_o}), 64'd0);
      wb_waited = 0; host_waited = 0;
      ret_q.delete();
      pend_wr = 0;
      e_en = 0; e_we = 0; e_addr = '0; e_wdata = '0;
      m_gnt_rd = 0; m_gnt_wb = 0; m_gnt_host = 0;
    end else begin
      // a write granted last cycle is now on the bus and will land in memory
      if (pend_wr) ref_mem[pend_addr] = pend_data;
      pend_wr = 0;

      check("ub_en", 64'(ub_en_o), 64'(e_en));
      if (e_en) check("ub_we", 64'(ub_we_o), 64'(e_we));
      check("ub_addr",  64'(ub_addr_o), 64'(e_addr));
      check("ub_wdata", ub_wdata_o, e_wdata);

      if (ret_q.size() > 0 && ret_q[0].due == cyc) begin
        r = ret_q.pop_front();
        check("rd_rvalid",   64'(rd_rvalid_o),   64'(!r.to_host));
        check("host_rvalid", 64'(host_rvalid_o), 64'(r.to_host));
        if (r.to_host) check("host_rdata", host_rdata_o, r.data);
        else           check("rd_rdata",   rd_rdata_o,   r.data);
      end else begin
        check("rvalid_idle", 64'({rd_rvalid_o, host_rvalid_o}), 64'd0);
      end

      erd = 0; ewb = 0; ehost = 0;
      if (wb_req_i && wb_waited >= MAX_WAIT)          ewb   = 1;
      else if (host_req_i && host_waited >= MAX_WAIT) ehost = 1;
      else if (rd_req_i)                              erd   = 1;
      else if (wb_req_i)                              ewb   = 1;
      else if (host_req_i)                            ehost = 1;

      check("rd_gnt",   64'(rd_gnt_o),   64'(erd));
      check("wb_gnt",   64'(wb_gnt_o),   64'(ewb));
      check("host_gnt", 64'(host_gnt_o), 64'(ehost));

      m_gnt_rd = erd; m_gnt_wb = ewb; m_gnt_host = ehost;
      e_en = erd | ewb | ehost;
      e_we = ewb | (ehost & host_we_i);
      if (ewb) begin
        e_addr = wb_addr_i; e_wdata = wb_wdata_i;
        pend_wr = 1; pend_addr = wb_addr_i; pend_data = wb_wdata_i;
      end else if (ehost) begin
        e_addr = host_addr_i; e_wdata = host_wdata_i;
        if (host_we_i) begin
          pend_wr = 1; pend_addr = host_addr_i; pend_data = host_wdata_i;
        end else begin
          ret_q.push_back('{cyc + 2, 1'b1, ref_mem[host_addr_i]});
        end
      end else if (erd) begin
        e_addr = rd_addr_i;
        ret_q.push_back('{cyc + 2, 1'b0, ref_mem[rd_addr_i]});
      end

      wb_waited   = (wb_req_i   && !ewb)   ? wb_waited + 1   : 0;
      host_waited = (host_req_i && !ehost) ? host_waited + 1 : 0;
    end
    cyc++;
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle(input int n);
    rd_req_i = 0; wb_req_i = 0; host_req_i = 0;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int lat_wb, lat_host;

    for (int i = 0; i < int'(DEPTH); i++) begin
      mem[i]     = {32'(i) ^ 32'h5A5A_0000, 32'hC0DE_0000 | 32'(i)};
      ref_mem[i] = mem[i];
    end

    rst_i = 1;
    rd_req_i = 0; rd_addr_i = '0;
    wb_req_i = 0; wb_addr_i = '0; wb_wdata_i = '0;
    host_req_i = 0; host_we_i = 0; host_addr_i = '0; host_wdata_i = '0;
    @(posedge clk_i); #1;
    step(); step();
    rst_i = 0;
    idle(2);

    // Reset mid-stream: rd read granted, then reset before its data returns.
    rd_req_i = 1; rd_addr_i = 12'h010;
    step();
    rst_i = 1;
    step(); step();
    rst_i = 0; rd_req_i = 0;
    step(); step(); step();
    check("rst_drop_rvalid", 64'(d_rd_rvalid), 64'd0);

    // rd alone streaming 0x010..0x013
    rd_req_i = 1;
    for (int a = 'h10; a <= 'h13; a++) begin
      rd_addr_i = ADDR_W'(a);
      step();
    end
    idle(4);

    // rd continuous, wb promoted after MAX_WAIT cycles
    rd_req_i = 1; wb_req_i = 1; wb_addr_i = 12'h0A0; wb_wdata_i = 64'h1111_2222_3333_4444;
    lat_wb = -1;
    for (int i = 0; i < 20 && lat_wb < 0; i++) begin
      rd_addr_i = ADDR_W'($urandom_range(0, 31));
      step();
      if (d_gnt_wb) begin lat_wb = i; wb_req_i = 0; end
    end
    check("wb_age_latency", 64'(lat_wb), 64'(MAX_WAIT));
    step(); step();
    idle(3);

    // rd idle, wb and host together: wb first, host next
    wb_req_i = 1; wb_addr_i = 12'h0B0; wb_wdata_i = 64'hAAAA_BBBB_CCCC_DDDD;
    host_req_i = 1; host_we_i = 1; host_addr_i = 12'h0B1; host_wdata_i = 64'h0123_4567_89AB_CDEF;
    step();
    check("pair_wb_first", 64'(d_gnt_wb), 64'd1);
    wb_req_i = 0;
    step();
    check("pair_host_next", 64'(d_gnt_host), 64'd1);
    idle(3);

    // rd continuous, wb and host age together: wb at MAX_WAIT, host one later
    rd_req_i = 1; wb_req_i = 1; host_req_i = 1; host_we_i = 0; host_addr_i = 12'h0B0;
    lat_wb = -1; lat_host = -1;
    for (int i = 0; i < 30 && (lat_wb < 0 || lat_host < 0); i++) begin
      rd_addr_i = ADDR_W'($urandom_range(0, 31));
      step();
      if (d_gnt_wb)   begin lat_wb = i;   wb_req_i = 0;   end
      if (d_gnt_host) begin lat_host = i; host_req_i = 0; end
    end
    check("both_aged_wb",   64'(lat_wb),   64'(MAX_WAIT));
    check("both_aged_host", 64'(lat_host), 64'(MAX_WAIT + 1));
    idle(4);

    // host write then read-back of the same address
    host_req_i = 1; host_we_i = 1; host_addr_i = 12'h123; host_wdata_i = 64'hDEAD_BEEF;
    step();
    host_we_i = 0;
    step();
    host_req_i = 0;
    step(); step();
    check("raw_host_rvalid", 64'(d_host_rvalid), 64'd1);
    check("raw_host_rdata",  d_host_rdata, 64'hDEAD_BEEF);
    check("raw_rd_rvalid",   64'(d_rd_rvalid), 64'd0);
    idle(2);

    // host read then rd read on the next cycle
    host_req_i = 1; host_we_i = 0; host_addr_i = 12'h200;
    step();
    host_req_i = 0; rd_req_i = 1; rd_addr_i = 12'h201;
    step();
    rd_req_i = 0;
    step();
    check("interleave_host_rv", 64'({d_host_rvalid, d_rd_rvalid}), 64'b10);
    step();
    check("interleave_rd_rv", 64'({d_host_rvalid, d_rd_rvalid}), 64'b01);
    idle(2);

    // Randomized traffic over a small address window so RAW hazards are common
    for (int i = 0; i < 3000; i++) begin
      int unsigned rd_pct;
      rd_pct = (i < 1500) ? 60 : 95;
      if (!rd_req_i || m_gnt_rd) begin
        rd_req_i  = ($urandom_range(0, 99) < rd_pct);
        rd_addr_i = ADDR_W'($urandom_range(0, 15));
      end
      if (!wb_req_i || m_gnt_wb) begin
        wb_req_i   = ($urandom_range(0, 99) < 30);
        wb_addr_i  = ADDR_W'($urandom_range(0, 15));
        wb_wdata_i = {$urandom, $urandom};
      end
      if (!host_req_i || m_gnt_host) begin
        host_req_i   = ($urandom_range(0, 99) < 30);
        host_we_i    = 1'($urandom_range(0, 1));
        host_addr_i  = ADDR_W'($urandom_range(0, 15));
        host_wdata_i = {$urandom, $urandom};
      end
      rst_i = (i >= 1000 && i < 1002) || (i >= 2200 && i < 2203);
      step();
    end
    rst_i = 0;
    idle(4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/unified_buffer_arbiter.md
Name: unified_buffer_arbiter

Overview:
Arbitrates the single-port unified buffer between three requesters.
- Array-feed read controller (rd): read-only, highest base priority.
- Accumulator writeback (wb): write-only.
- Host port (host): read or write.

The block issues one registered memory command per cycle and routes returned read data back to the correct requester. Age-based promotion prevents rd streaming from starving wb and host.

Parameters:
ADDR_W, 12, unified buffer address width
DATA_W, 64, unified buffer word width
MAX_WAIT, 8, cycles a wb/host request may wait before it is promoted (range 1..255)

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-high
rd_req_i  in  1  array-feed read request
rd_addr_i  in  ADDR_W  array-feed read address
rd_gnt_o  out  1  array-feed grant
rd_rdata_o  out  DATA_W  array-feed read data
rd_rvalid_o  out  1  array-feed read data valid
wb_req_i  in  1  writeback write request
wb_addr_i  in  ADDR_W  writeback address
wb_wdata_i  in  DATA_W  writeback data
wb_gnt_o  out  1  writeback grant
host_req_i  in  1  host request
host_we_i  in  1  host write (1) / read (0)
host_addr_i  in  ADDR_W  host address
host_wdata_i  in  DATA_W  host write data
host_gnt_o  out  1  host grant
host_rdata_o  out  DATA_W  host read data
host_rvalid_o  out  1  host read data valid
ub_en_o  out  1  memory enable
ub_we_o  out  1  memory write enable
ub_addr_o  out  ADDR_W  memory address
ub_wdata_o  out  DATA_W  memory write data
ub_rdata_i  in  DATA_W  memory read data, valid 1 cycle after a read command

Behaviour:
- Reset (asynchronous, any cycle):
  - ub_en_o, ub_we_o, rd_rvalid_o, host_rvalid_o = 0; ub_addr_o, ub_wdata_o = 0.
  - Wait counters and read-tag pipeline cleared.
  - Grants forced 0 while rst_i is high.
  - Reads in flight at reset are dropped: no rvalid is produced for them.
- Request handshake:
  - A requester holds req, addr and data stable until it sees gnt in the same cycle.
  - Grant is combinational from req and the wait counters.
  - A transfer completes on a cycle where req and gnt are both high.
  - At most one grant per cycle. No grant when no request is pending.
- Arbitration order, highest priority first:
  1. wb aged
  2. host aged
  3. rd
  4. wb
  5. host
- Aging:
  - Per-requester 8-bit counter for wb and host.
  - Increments each cycle that req=1 and gnt=0; saturates at MAX_WAIT.
  - Cleared on that requester's grant or whenever its req=0.
  - "Aged" means counter == MAX_WAIT.
  - Consequence: under continuous rd requests, a waiting wb or host is granted exactly MAX_WAIT cycles after it first asserts req.
- Memory command:
  - Registered. Grant in cycle N drives ub_en_o=1 in cycle N+1, with the granted requester's addr/wdata.
  - ub_we_o=1 for a wb grant or a host grant with host_we_i=1.
  - ub_en_o=0 in a cycle following no grant; ub_addr_o and ub_wdata_o hold their last values.
- Read return:
  - A 2-bit tag (none/rd/host) is registered with each command and delayed one more stage to align with ub_rdata_i.
  - rd_rvalid_o or host_rvalid_o asserts in cycle N+2 for a read granted in cycle N.
  - rd_rdata_o and host_rdata_o both carry ub_rdata_i; only the matching valid is high.
  - Read latency from grant: 2 cycles. Throughput: 1 access per cycle.
- Back-to-back and ordering:
  - Consecutive grants to different requesters are allowed with no bubble.
  - A write followed by a read of the same address returns the new data, because commands execute in grant order.
- No flow control on read returns: rd and host must always accept rvalid.

Test Plan:
1. Reset mid-stream: rd read granted at N, rst_i asserted at N+1 -> rd_rvalid_o stays 0, ub_en_o=0 immediately, grants 0 during reset.
2. rd alone, addrs 0x010..0x013 on consecutive cycles -> rd_gnt_o=1 each cycle, ub_addr_o=0x010..0x013 at N+1..N+4, rd_rvalid_o at N+2..N+5 with the memory-model data.
3. rd continuously requesting, wb_req_i raised at cycle 0, MAX_WAIT=8 -> wb_gnt_o=1 only at cycle 8 (rd_gnt_o=0 that cycle), ub_we_o=1 at cycle 9, rd resumes at cycle 9.
4. rd idle, wb and host requesting simultaneously -> wb granted cycle 0, host cycle 1. With rd also continuous and both aged in the same cycle -> wb granted first, host the next cycle.
5. Host writes 0xDEADBEEF to 0x123, then host reads 0x123 the next cycle -> host_rvalid_o 2 cycles after the read grant with host_rdata_o=0xDEADBEEF, rd_rvalid_o=0.
6. Interleaved host read at N and rd read at N+1 -> host_rvalid_o at N+2, rd_rvalid_o at N+3, never both high in one cycle.
